// File: rtl/uart_defs.sv
// Shared UART constants and types used by the transmit queue and the rs232
// serializer/deserializer benches.
package uart_defs;

    localparam int BYTE_W = 8;
    localparam int CLK_HZ = 12000000;
    localparam int BAUD = 9600;
    // System clocks per serial bit period.
    localparam int PERIOD = CLK_HZ / BAUD;

    typedef logic [BYTE_W-1:0] uart_byte_t;

    localparam uart_byte_t FILL_BYTE_DEF = 8'hFF;

endpackage

// File: rtl/uart_tx_queue_ram.sv
// Simple dual-port byte store: one synchronous write port and a registered
// read port, shaped so that it maps onto iCE40 block RAM.
module uart_tx_queue_ram #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int WORDS = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [WORDS];
    logic [DATA_W-1:0] rdata_reg;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata_reg <= mem[raddr];
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue feeding a free-running rs232 serializer: presents the head byte
// (or a fill byte when empty) and pops on each rising edge of data_clk.
module uart_tx_queue
    import uart_defs::*;
#(
    parameter int         DEPTH_LOG2 = 4,
    parameter uart_byte_t FILL_BYTE  = FILL_BYTE_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [BYTE_W-1:0]     wr_data,
    input  logic                  data_clk,
    output logic [BYTE_W-1:0]     data_byte,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow
);

    localparam int                DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_LVL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] ONE_LVL   = (DEPTH_LOG2 + 1)'(1);

    logic                  dclk_q_reg;
    logic [DEPTH_LOG2-1:0] rd_ptr_reg;
    logic [DEPTH_LOG2-1:0] wr_ptr_reg;
    logic [DEPTH_LOG2:0]   level_reg;
    logic [DEPTH_LOG2:0]   level_next;
    logic                  full_reg;
    logic                  empty_reg;
    logic                  overflow_reg;
    logic                  out_valid_reg;
    logic [BYTE_W-1:0]     ram_rdata;

    logic take;
    logic push;
    logic pop;

    assign take = data_clk & ~dclk_q_reg;
    // A take while the output still shows the fill byte consumes only the fill.
    assign pop  = take & out_valid_reg;
    // Acceptance looks only at the level at the start of the cycle.
    assign push = wr_en & ~full_reg;

    always_comb begin
        level_next = level_reg;
        case ({push, pop})
            2'b10:   level_next = level_reg + ONE_LVL;
            2'b01:   level_next = level_reg - ONE_LVL;
            default: level_next = level_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dclk_q_reg    <= 1'b1;
            rd_ptr_reg    <= '0;
            wr_ptr_reg    <= '0;
            level_reg     <= '0;
            full_reg      <= 1'b0;
            empty_reg     <= 1'b1;
            overflow_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            dclk_q_reg <= data_clk;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            level_reg <= level_next;
            full_reg  <= (level_next == DEPTH_LVL);
            empty_reg <= (level_next == '0);
            if (wr_en && full_reg) begin
                overflow_reg <= 1'b1;
            end
            // Tracks the RAM read register, which samples mem[rd_ptr_reg].
            out_valid_reg <= (level_reg != '0);
        end
    end

    uart_tx_queue_ram #(
        .ADDR_W (DEPTH_LOG2),
        .DATA_W (BYTE_W)
    ) u_ram (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_reg),
        .wdata (wr_data),
        .raddr (rd_ptr_reg),
        .rdata (ram_rdata)
    );

    // Both mux inputs are registers; the fill select is the registered valid.
    assign data_byte = out_valid_reg ? ram_rdata : FILL_BYTE;
    assign full      = full_reg;
    assign empty     = empty_reg;
    assign level     = level_reg;
    assign overflow  = overflow_reg;

endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed bench for uart_tx_queue; the serializer is modelled by driving
// data_clk and recording data_byte at each rising edge.
module tb_uart_tx_queue;
    import uart_defs::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       data_clk = 1'b0;
    logic [7:0] data_byte;
    logic       full;
    logic       empty;
    logic [4:0] level;
    logic       overflow;

    int vectors = 0;
    int miscompares = 0;

    uart_tx_queue #(
        .DEPTH_LOG2 (4),
        .FILL_BYTE  (8'hFF)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .data_clk  (data_clk),
        .data_byte (data_byte),
        .full      (full),
        .empty     (empty),
        .level     (level),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        wr_en = 1'b1;
        wr_data = b;
        step();
        wr_en = 1'b0;
    endtask

    // One serializer byte slot: latch data_byte on the rising edge, settle.
    task automatic serial_latch(output logic [7:0] b);
        b = data_byte;
        data_clk = 1'b1;
        step();
        step();
        data_clk = 1'b0;
        step();
        step();
        step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] b;
        data_clk = 1'b1;
        rst = 1'b1;
        repeat (3) step();
        vectors++;
        if (data_byte !== 8'hFF) begin
            $display("FAIL reset_data_byte got %h want ff", data_byte); miscompares++;
        end
        vectors++;
        if (level !== 5'd0 || empty !== 1'b1 || full !== 1'b0 || overflow !== 1'b0) begin
            $display("FAIL reset_flags got level=%0d empty=%b full=%b ovf=%b want 0/1/0/0",
                     level, empty, full, overflow); miscompares++;
        end
        rst = 1'b0;
        step();
        step();
        data_clk = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            serial_latch(b);
            vectors++;
            if (b !== 8'hFF || data_byte !== 8'hFF) begin
                $display("FAIL idle_byte[%0d] got latched=%h out=%h want ff", i, b, data_byte);
                miscompares++;
            end
            vectors++;
            if (level !== 5'd0 || empty !== 1'b1) begin
                $display("FAIL idle_level[%0d] got level=%0d empty=%b want 0/1", i, level, empty);
                miscompares++;
            end
        end
        $display("test_reset done");
    endtask

    task automatic test_ordered_drain();
        logic [7:0] b;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            push_byte(8'h31 + 8'(i));
            vectors++;
            if (level !== 5'(i + 1)) begin
                $display("FAIL drain_fill_level[%0d] got %0d want %0d", i, level, i + 1);
                miscompares++;
            end
        end
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            serial_latch(b);
            vectors++;
            if (b !== 8'h31 + 8'(i)) begin
                $display("FAIL drain_byte[%0d] got %h want %h", i, b, 8'h31 + 8'(i));
                miscompares++;
            end
            vectors++;
            if (level !== 5'(4 - i)) begin
                $display("FAIL drain_level[%0d] got %0d want %0d", i, level, 4 - i);
                miscompares++;
            end
        end
        for (int i = 0; i < 2; i++) begin
            serial_latch(b);
            vectors++;
            if (b !== 8'hFF) begin
                $display("FAIL drain_fill[%0d] got %h want ff", i, b); miscompares++;
            end
        end
        $display("test_ordered_drain done");
    endtask

    task automatic test_full_overflow();
        logic [7:0] b;
        do_reset();
        data_clk = 1'b0;
        for (int i = 0; i < 17; i++) begin
            push_byte(8'h40 + 8'(i));
            if (i == 14) begin
                vectors++;
                if (full !== 1'b0 || level !== 5'd15) begin
                    $display("FAIL full_at15 got full=%b level=%0d want 0/15", full, level);
                    miscompares++;
                end
            end
            if (i == 15) begin
                vectors++;
                if (full !== 1'b1 || level !== 5'd16 || overflow !== 1'b0) begin
                    $display("FAIL full_at16 got full=%b level=%0d ovf=%b want 1/16/0",
                             full, level, overflow);
                    miscompares++;
                end
            end
        end
        vectors++;
        if (overflow !== 1'b1 || level !== 5'd16) begin
            $display("FAIL overflow_set got ovf=%b level=%0d want 1/16", overflow, level);
            miscompares++;
        end
        step();
        step();
        for (int i = 0; i < 16; i++) begin
            serial_latch(b);
            vectors++;
            if (b !== 8'h40 + 8'(i)) begin
                $display("FAIL full_drain[%0d] got %h want %h", i, b, 8'h40 + 8'(i));
                miscompares++;
            end
        end
        vectors++;
        if (empty !== 1'b1 || full !== 1'b0 || overflow !== 1'b1) begin
            $display("FAIL overflow_sticky got empty=%b full=%b ovf=%b want 1/0/1",
                     empty, full, overflow);
            miscompares++;
        end
        do_reset();
        vectors++;
        if (overflow !== 1'b0) begin
            $display("FAIL overflow_clear got %b want 0", overflow); miscompares++;
        end
        $display("test_full_overflow done");
    endtask

    task automatic test_fill_race();
        logic [7:0] b;
        do_reset();
        // Push in the same cycle as the data_clk rising edge.
        b = data_byte;
        wr_en = 1'b1;
        wr_data = 8'hA5;
        data_clk = 1'b1;
        step();
        wr_en = 1'b0;
        vectors++;
        if (b !== 8'hFF || level !== 5'd1) begin
            $display("FAIL race_same got latched=%h level=%0d want ff/1", b, level);
            miscompares++;
        end
        step();
        data_clk = 1'b0;
        step();
        step();
        serial_latch(b);
        vectors++;
        if (b !== 8'hA5 || level !== 5'd0) begin
            $display("FAIL race_same_next got %h level=%0d want a5/0", b, level);
            miscompares++;
        end
        // Push one cycle before the rising edge.
        push_byte(8'hA5);
        b = data_byte;
        data_clk = 1'b1;
        step();
        vectors++;
        if (b !== 8'hFF || level !== 5'd1) begin
            $display("FAIL race_before got latched=%h level=%0d want ff/1", b, level);
            miscompares++;
        end
        step();
        data_clk = 1'b0;
        step();
        step();
        serial_latch(b);
        vectors++;
        if (b !== 8'hA5 || level !== 5'd0) begin
            $display("FAIL race_before_next got %h level=%0d want a5/0", b, level);
            miscompares++;
        end
        $display("test_fill_race done");
    endtask

    task automatic test_back_to_back();
        logic [7:0] b;
        logic [7:0] expect_head;
        do_reset();
        push_byte(8'h10);
        step();
        step();
        expect_head = 8'h10;
        for (int i = 0; i < 40; i++) begin
            b = data_byte;
            wr_en = 1'b1;
            wr_data = 8'h80 + 8'(i);
            data_clk = 1'b1;
            step();
            wr_en = 1'b0;
            vectors++;
            if (b !== expect_head || level !== 5'd1) begin
                $display("FAIL simul[%0d] got latched=%h level=%0d want %h/1",
                         i, b, level, expect_head);
                miscompares++;
            end
            data_clk = 1'b0;
            step();
            vectors++;
            if (data_byte !== 8'h80 + 8'(i)) begin
                $display("FAIL simul_out[%0d] got %h want %h", i, data_byte, 8'h80 + 8'(i));
                miscompares++;
            end
            expect_head = 8'h80 + 8'(i);
            step();
        end
        serial_latch(b);
        vectors++;
        if (b !== 8'hA7 || level !== 5'd0 || data_byte !== 8'hFF) begin
            $display("FAIL simul_tail got %h level=%0d out=%h want a7/0/ff", b, level, data_byte);
            miscompares++;
        end
        $display("test_back_to_back done");
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            push_byte(8'h60 + 8'(i));
        end
        step();
        step();
        vectors++;
        if (level !== 5'd6 || data_byte !== 8'h60) begin
            $display("FAIL mid_before got level=%0d out=%h want 6/60", level, data_byte);
            miscompares++;
        end
        do_reset();
        vectors++;
        if (level !== 5'd0 || data_byte !== 8'hFF || empty !== 1'b1) begin
            $display("FAIL mid_after got level=%0d out=%h empty=%b want 0/ff/1",
                     level, data_byte, empty);
            miscompares++;
        end
        push_byte(8'h77);
        step();
        step();
        serial_latch(b);
        vectors++;
        if (b !== 8'h77) begin
            $display("FAIL mid_first got %h want 77", b); miscompares++;
        end
        serial_latch(b);
        vectors++;
        if (b !== 8'hFF) begin
            $display("FAIL mid_fill got %h want ff", b); miscompares++;
        end
        $display("test_reset_mid done");
    endtask

    initial begin
        test_reset();
        test_ordered_drain();
        test_full_overflow();
        test_fill_race();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_tx_queue.md
# uart_tx_queue

Byte queue that sits directly upstream of `rs232_send`, feeding its `data_byte` input and consuming its `data_clk` strobe. Producers such as the PDM sample packer push bytes at system-clock rate. The queue presents them one at a time to the serializer, which runs at one byte per 10 bit periods. When the queue is empty it presents a fill byte, so the free-running serializer always has defined data.

## Interface
- `DEPTH_LOG2`, 4: queue depth is 2^DEPTH_LOG2 bytes.
- `FILL_BYTE`, 8'hFF: byte presented when the queue is empty.
- `clk` in 1: system clock (12 MHz); all logic on rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `wr_en` in 1: push strobe, one byte per cycle in which it is high.
- `wr_data` in 8: byte to push.
- `data_clk` in 1: from `rs232_send`. A rising edge means the serializer has latched `data_byte`.
- `data_byte` out 8: registered byte to `rs232_send`.
- `full` out 1: level == 2^DEPTH_LOG2.
- `empty` out 1: level == 0.
- `level` out DEPTH_LOG2+1: bytes stored.
- `overflow` out 1: sticky; a push was dropped.

## Operation
- Circular buffer with read pointer, write pointer and level counter.
  - Pointers are DEPTH_LOG2 bits and wrap naturally modulo 2^DEPTH_LOG2.
  - The level counter is DEPTH_LOG2+1 bits.
- Edge detect:
  - `dclk_q` <= `data_clk` every cycle.
  - `take` = `data_clk & ~dclk_q`.
- Output register pair `data_byte` / `out_valid`, updated every cycle from state after that cycle's updates:
  - When level != 0: mem[head], out_valid = 1.
  - When level == 0: FILL_BYTE, out_valid = 0.
- Pop occurs when `take & out_valid`. A `take` with out_valid = 0 consumes the fill byte and pops nothing.
  - This includes the case where a push has already raised level but the output register still shows FILL_BYTE.
- Push is accepted when `wr_en` is high and level < 2^DEPTH_LOG2 at the start of the cycle.
  - The check ignores a pop in the same cycle.
  - A push while full is dropped, sets `overflow`, and leaves the memory unchanged.
- Simultaneous accepted push and pop: level unchanged, both pointers advance.
- `overflow` clears only on `rst`.
- States: no explicit FSM; the behaviour is fully determined by level and out_valid.

## Timing
- Reset values:
  - `data_byte` = FILL_BYTE, out_valid = 0.
  - `full` = 0, `empty` = 1, `level` = 0, `overflow` = 0.
  - Pointers = 0.
  - `dclk_q` = 1, so a `data_clk` held high through reset causes no spurious pop.
- `rst` mid-operation discards queued bytes. The next cycle matches post-reset state.
- Push in cycle t: `level` / `empty` / `full` update at t+1. `data_byte` shows the byte at t+2 if the queue was empty.
- `take` in cycle t with out_valid: `level` decrements at t+1, and `data_byte` shows the next head or FILL_BYTE at t+2.
  - This 2-cycle latency is negligible against a 1250-cycle bit period.
- `full`, `empty` and `level` are registered and change only on a clock edge after push/pop.
- `wr_data` is sampled only in cycles with `wr_en` high.

## Structure
- Shared package `uart_defs`:
  - FILL_BYTE default.
  - Baud PERIOD constant (12000000/9600).
  - Byte width 8.
  - These are also used by `rs232_send` / `rs232_recv` benches.
- One natural sub-module, `uart_tx_queue_ram`: 2^DEPTH_LOG2 x 8 simple dual-port memory with one synchronous write port and a registered read.
  - It maps to iCE40 block RAM at larger depths.
  - Control logic stays in `uart_tx_queue`.

## Test plan
- **Reset idle:** assert `rst` 3 cycles with `data_clk` = 1, then release and toggle `data_clk` with no pushes.
  - `data_byte` stays 8'hFF.
  - `level` stays 0 and `empty` stays 1.
  - No pop occurs.
- **Ordered drain:** push 8'h31..8'h35 on consecutive cycles, with `rs232_send` (PERIOD 1250) connected and `rs232_recv` looped back.
  - The receiver yields "1","2","3","4","5", then 8'hFF bytes.
  - `level` goes 5 -> 0.
- **Full/overflow:** with `data_clk` held 0, push 17 bytes into DEPTH_LOG2 = 4.
  - `full` = 1 after the 16th push.
  - The 17th byte is dropped and `overflow` = 1.
  - Drain returns the first 16 bytes in order.
  - `overflow` stays 1 until `rst`.
- **Fill race:** queue empty; push 8'hA5 in the same cycle as the `data_clk` rising edge, and again one cycle before it.
  - Neither edge pops.
  - 8'hA5 is transmitted on the following byte slot.
- **Simultaneous push/pop at level 1:** `wr_en` together with `take`.
  - `level` stays 1.
  - `data_byte` becomes the new byte 2 cycles later.
  - Pointer wrap is exercised by 40 such cycles with no data corruption.
- **Reset mid-drain:** assert `rst` with 6 bytes queued.
  - `level` = 0 and `data_byte` = 8'hFF next cycle.
  - The first byte pushed afterwards is the next real byte transmitted.
